// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-test sequencer.
//   state_e    : sequencer states
//   LfsrSeed   : LFSR reset value
//   LfsrTaps   : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   DefResultW : default width of the millisecond result
//   lfsr_step  : one Galois LFSR step
package rt_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StGo,
      StFalse,
      StDone
   } state_e;

   localparam logic [15:0] LfsrSeed   = 16'hACE1;
   localparam logic [15:0] LfsrTaps   = 16'hB400;
   localparam int unsigned DefResultW = 14;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LfsrTaps : 16'h0000);
   endfunction

endpackage

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit Galois LFSR, stepping every clock.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, loads LfsrSeed
//   lfsr_o : current LFSR state (never zero once seeded)
module rt_lfsr16
   import rt_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-test sequencer feeding the LED PWM bright/dim select.
// A start press waits MIN_DELAY_MS + random ms with the LED dim, then drives it
// bright and counts ms until the react press; reports reaction time, false start
// or timeout.
// Ports:
//   clk          : system clock
//   rstn         : synchronous active-low reset
//   start_btn    : raw start button (async, active-high)
//   react_btn    : raw react button (async, active-high)
//   bright       : 1 = bright, 0 = dim
//   result_ms    : last reaction time in ms
//   result_valid : one-cycle pulse when result_ms updates
//   false_start  : react pressed during the wait (level)
//   timeout      : no react within TIMEOUT_MS (level)
//   busy         : high in ARM and GO
//   best_ms      : best reaction time; only live with BEST_TIME_EN defined,
//                  otherwise tied to zero
// Build option: define BEST_TIME_EN to build the best-time tracker.
module reaction_ctrl
   import rt_pkg::*;
#(
   parameter int unsigned TICKS_PER_MS = 50000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_BITS    = 11,
   parameter int unsigned TIMEOUT_MS   = 9999,
   parameter int unsigned RESULT_W     = DefResultW
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start_btn,
   input  logic                react_btn,
   output logic                bright,
   output logic [RESULT_W-1:0] result_ms,
   output logic                result_valid,
   output logic                false_start,
   output logic                timeout,
   output logic                busy,
   output logic [RESULT_W-1:0] best_ms
);

   localparam int unsigned TickW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [TickW-1:0]    TickMax    = TickW'(TICKS_PER_MS - 1);
   localparam logic [RESULT_W-1:0] TimeoutVal = RESULT_W'(TIMEOUT_MS);
   localparam logic [RESULT_W-1:0] MinDelay   = RESULT_W'(MIN_DELAY_MS);

   state_e               state_q, state_d;
   logic [2:0]           start_sync_q;
   logic [2:0]           react_sync_q;
   logic [TickW-1:0]     tick_q, tick_d;
   logic [RESULT_W-1:0]  ms_cnt_q, ms_cnt_d;
   logic [RESULT_W-1:0]  ms_inc;
   logic [RESULT_W-1:0]  delay_q, delay_d;
   logic [RESULT_W-1:0]  result_q, result_d;
   logic                 valid_q, valid_d;
   logic                 false_q, false_d;
   logic                 timeout_q, timeout_d;
   logic                 start_pulse;
   logic                 react_pulse;
   logic                 ms_tick;
   logic                 entry;
   logic [15:0]          lfsr;
   logic                 unused_lfsr;

   rt_lfsr16 u_lfsr (
      .clk_i  (clk),
      .rst_ni (rstn),
      .lfsr_o (lfsr)
   );

   // Only the low RAND_BITS feed the delay.
   assign unused_lfsr = ^lfsr[15:RAND_BITS];

   // Bit 0/1 form the 2-flop synchronizer; bit 2 is the edge-detect history.
   assign start_pulse = start_sync_q[1] & ~start_sync_q[2];
   assign react_pulse = react_sync_q[1] & ~react_sync_q[2];

   assign ms_tick = (tick_q == TickMax);
   assign ms_inc  = (ms_cnt_q == '1) ? ms_cnt_q : ms_cnt_q + RESULT_W'(1);

   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      false_d   = false_q;
      timeout_d = timeout_q;
      unique case (state_q)
         StIdle, StFalse, StDone: begin
            if (start_pulse) begin
               delay_d   = MinDelay + RESULT_W'(lfsr[RAND_BITS-1:0]);
               false_d   = 1'b0;
               timeout_d = 1'b0;
               state_d   = StArm;
            end
         end
         StArm: begin
            if (react_pulse) begin
               false_d = 1'b1;
               state_d = StFalse;
            end else if (ms_tick && (ms_inc == delay_q)) begin
               // Compare the post-tick count so GO starts exactly delay ms after ARM entry.
               state_d = StGo;
            end
         end
         StGo: begin
            if (react_pulse) begin
               result_d = ms_cnt_q;
               valid_d  = 1'b1;
               state_d  = StDone;
            end else if (ms_cnt_q >= TimeoutVal) begin
               result_d  = TimeoutVal;
               timeout_d = 1'b1;
               valid_d   = 1'b1;
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Tick and ms counters restart on every state change.
   always_comb begin
      entry = (state_d != state_q);
      if (entry || ms_tick) begin
         tick_d = '0;
      end else begin
         tick_d = tick_q + TickW'(1);
      end
      if (entry) begin
         ms_cnt_d = '0;
      end else if (ms_tick) begin
         ms_cnt_d = ms_inc;
      end else begin
         ms_cnt_d = ms_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         start_sync_q <= '0;
         react_sync_q <= '0;
         tick_q       <= '0;
         ms_cnt_q     <= '0;
         delay_q      <= '0;
         result_q     <= '0;
         valid_q      <= 1'b0;
         false_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_sync_q <= {start_sync_q[1:0], start_btn};
         react_sync_q <= {react_sync_q[1:0], react_btn};
         tick_q       <= tick_d;
         ms_cnt_q     <= ms_cnt_d;
         delay_q      <= delay_d;
         result_q     <= result_d;
         valid_q      <= valid_d;
         false_q      <= false_d;
         timeout_q    <= timeout_d;
      end
   end

`ifdef BEST_TIME_EN
   logic [RESULT_W-1:0] best_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         best_q <= '1;
      end else if (valid_q && !timeout_q && (result_q < best_q)) begin
         best_q <= result_q;
      end
   end

   assign best_ms = best_q;
`else
   assign best_ms = '0;
`endif

   assign bright       = (state_q == StGo);
   assign busy         = (state_q == StArm) || (state_q == StGo);
   assign result_ms    = result_q;
   assign result_valid = valid_q;
   assign false_start  = false_q;
   assign timeout      = timeout_q;

endmodule
